// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // RV32I load/store funct3 encodings
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Base byte-enable patterns, shifted into place by the byte offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Stores only have B/H/W; loads add the unsigned BU/HU variants
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    is_half = (f3[1:0] == 2'b01);
  endfunction

  function automatic logic is_word(input logic [2:0] f3);
    is_word = (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half from the read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [15:0] low;

  // Shift the addressed lane down to bit 0, then extend by access type
  always_comb begin
    low  = 16'(rdata >> {offset, 3'b000});
    data = '0;
    case (funct3)
      F3_B:    data = {{24{low[7]}}, low[7:0]};
      F3_BU:   data = {24'b0, low[7:0]};
      F3_H:    data = {{16{low[15]}}, low};
      F3_HU:   data = {16'b0, low};
      F3_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: runs one byte/half/word access on a req/gnt/rvalid data
// port and returns a single-cycle completion pulse to writeback.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses raise
// resp_err instead of being silently aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, acc_addr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, load_data;
  logic                  err_q, err_d, acc_err;

  // Classify the incoming request: legality and alignment handling
  always_comb begin
    acc_addr = req_addr;
    acc_err  = !f3_legal(req_we, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (is_half(req_funct3) && req_addr[0])            acc_err = 1'b1;
    if (is_word(req_funct3) && req_addr[1:0] != 2'b00) acc_err = 1'b1;
`else
    if (is_half(req_funct3)) acc_addr[0]   = 1'b0;
    if (is_word(req_funct3)) acc_addr[1:0] = 2'b00;
`endif
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Next-state and capture logic for the single-outstanding access FSM
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = acc_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = acc_err;
          state_d  = acc_err ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request fields
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the asynchronous reset clears every captured field, so no stale request leaks out after an abandoned access.
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory port: word address, lane enables and lane-replicated store data
  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == REQ) begin
      mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      if (!we_q) begin
        mem_be = BE_WORD;
      end else begin
        case (funct3_q)
          F3_B: begin
            mem_be    = BE_BYTE << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          F3_H: begin
            mem_be    = BE_HALF << {addr_q[1], 1'b0};
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = BE_WORD;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver pushes expected memory
// requests and responses; a memory responder and a response monitor pop and
// compare them as the DUT presents them.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wd;
  } mem_exp_t;

  resp_exp_t   exp_q[$];
  mem_exp_t    mem_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          resp_seen = 0;
  int          gnt_delay = 0;
  int          req_cycles = 0;
  bit          rd_pending = 0;
  bit          hold_rv = 0;
  bit          stray_rv = 0;
  logic [31:0] mem_word = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input bit chk_wd);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.be = be; m.wdata = wd; m.chk_wd = chk_wd;
    mem_q.push_back(m);
  endtask

  // Present a request at a negedge, wait (bounded) for acceptance and push the
  // expected response due lat cycles after the accept cycle.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit push, output int acc_c);
    bit        ok = 0;
    resp_exp_t r;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("accept", 32'(ok), 32'd1);
    acc_c = cyc;
    if (push) begin
      r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + lat;
      exp_q.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && mem_q.size() == 0 && req_ready) begin done = 1; break; end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  initial begin
    int c, c1, c2, base;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    fork
      // Driver
      begin
        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_req",    32'(mem_req), 32'd0);
        check("rst_mem_addr",   mem_addr, 32'd0);
        check("rst_mem_be",     32'(mem_be), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // LW, earliest gnt/rvalid
        mem_word = 32'hDEADBEEF;
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, c);
        wait_idle();

        // Sub-word loads with sign/zero extension
        mem_word = 32'h80FF_0000;
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1, c);
        wait_idle();
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 1'b1, c);
        wait_idle();
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h000080FF, 1'b0, 3, 1'b1, c);
        wait_idle();
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 3, 1'b1, c);
        wait_idle();
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b100, 32'h12, 32'h0, 32'h000000FF, 1'b0, 3, 1'b1, c);
        wait_idle();

        // SH with gnt held low for 3 request cycles: resp 1 cycle after gnt
        gnt_delay = 3;
        exp_mem(1'b1, 32'h04, 4'b1100, 32'hABCDABCD, 1'b1);
        issue(1'b1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0, 1'b0, 5, 1'b1, c);
        wait_idle();
        gnt_delay = 0;

        // Store lane placement
        exp_mem(1'b1, 32'h00, 4'b1000, 32'hA5A5A5A5, 1'b1);
        issue(1'b1, 3'b000, 32'h03, 32'h000000A5, 32'h0, 1'b0, 2, 1'b1, c);
        wait_idle();
        exp_mem(1'b1, 32'h00, 4'b0010, 32'h77777777, 1'b1);
        issue(1'b1, 3'b000, 32'h01, 32'h12345677, 32'h0, 1'b0, 2, 1'b1, c);
        wait_idle();
        exp_mem(1'b1, 32'h08, 4'hF, 32'hCAFEF00D, 1'b1);
        issue(1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, c);
        wait_idle();
        exp_mem(1'b1, 32'h04, 4'b0011, 32'h01020102, 1'b1);
        issue(1'b1, 3'b001, 32'h04, 32'hFFFF0102, 32'h0, 1'b0, 2, 1'b1, c);
        wait_idle();

        // Misaligned accesses: trapped, or aligned down
        mem_word = 32'h11223344;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h0, 1'b1, 1, 1'b1, c);
        wait_idle();
        issue(1'b0, 3'b101, 32'h23, 32'h0, 32'h0, 1'b1, 1, 1'b1, c);
        wait_idle();
        issue(1'b1, 3'b010, 32'h0A, 32'h13572468, 32'h0, 1'b1, 1, 1'b1, c);
        wait_idle();
`else
        exp_mem(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h21, 32'h0, 32'h11223344, 1'b0, 3, 1'b1, c);
        wait_idle();
        mem_word = 32'hAABBCCDD;
        exp_mem(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b101, 32'h23, 32'h0, 32'h0000AABB, 1'b0, 3, 1'b1, c);
        wait_idle();
        exp_mem(1'b1, 32'h08, 4'hF, 32'h13572468, 1'b1);
        issue(1'b1, 3'b010, 32'h0A, 32'h13572468, 32'h0, 1'b0, 2, 1'b1, c);
        wait_idle();
`endif

        // Illegal funct3, then back-to-back request held on req_valid
        mem_word = 32'hDEADBEEF;
        exp_mem(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 1'b1, c1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, c2);
        check("accept_spacing", 32'(c2 - c1), 32'd2);
        wait_idle();
        issue(1'b1, 3'b100, 32'h18, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, c);
        wait_idle();
        issue(1'b0, 3'b111, 32'h18, 32'h0, 32'h0, 1'b1, 1, 1'b1, c);
        wait_idle();

        // Reset while the request is waiting for gnt
        gnt_delay = 1000;
        exp_mem(1'b0, 32'h30, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1'b0, 0, 1'b0, c);
        #2;
        check("req_mem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_mem_req",   32'(mem_req), 32'd0);
        check("rst_req_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        gnt_delay = 0;
        wait_idle();

        // Reset in WAIT, then a stray rvalid for the abandoned load
        hold_rv = 1;
        mem_word = 32'h55AA55AA;
        exp_mem(1'b0, 32'h34, 4'hF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h34, 32'h0, 32'h0, 1'b0, 0, 1'b0, c);
        @(negedge clk);
        #2;
        check("wait_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        check("rst_wait_mem_req",   32'(mem_req), 32'd0);
        @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b1;
        base = resp_seen;
        hold_rv = 0;
        stray_rv = 1;
        repeat (6) @(negedge clk);
        check("stray_rvalid_resp", 32'(resp_seen - base), 32'd0);
        check("stray_ready",       32'(req_ready), 32'd1);

        check("leftover_resp", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end

      // Response monitor
      forever begin
        resp_exp_t e;
        @(negedge clk);
        if (resp_valid) begin
          resp_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err",   32'(resp_err), 32'(e.err));
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end

      // Memory responder: gnt after gnt_delay request cycles, rvalid next cycle
      forever begin
        mem_exp_t m;
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
          rd_pending = 0;
          req_cycles = 0;
        end else if (stray_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0BAD0;
          stray_rv   = 0;
        end else if (rd_pending && !hold_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word;
          rd_pending = 0;
        end else if (mem_req) begin
          if (req_cycles == 0) begin
            if (mem_q.size() == 0) begin
              check("unexpected_mem_req", 32'd1, 32'd0);
            end else begin
              m = mem_q.pop_front();
              check("mem_we",   32'(mem_we), 32'(m.we));
              check("mem_addr", mem_addr, m.addr);
              check("mem_be",   32'(mem_be), 32'(m.be));
              if (m.chk_wd) check("mem_wdata", mem_wdata, m.wdata);
            end
          end
          req_cycles++;
          if (req_cycles > gnt_delay) begin
            mem_gnt    = 1'b1;
            rd_pending = !mem_we;
            req_cycles = 0;
          end
        end
      end

      // Watchdog
      begin
        repeat (20000) @(posedge clk);
        check("watchdog", 32'd1, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join_any
  end

endmodule
